// File: rtl/crossbar_pkg.sv
// Shared types and constants for the 2x2 crossbar arbiter.
//   xbar_state_t : per-output lock state
//   SEL_IN*      : crossbar select encoding (which input feeds an output)
//   DEST_OUT*    : destination encoding carried on in*_dest
package crossbar_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCK_IN1 = 2'd1,
        LOCK_IN2 = 2'd2
    } xbar_state_t;

    localparam logic SEL_IN1   = 1'b0;
    localparam logic SEL_IN2   = 1'b1;

    localparam logic DEST_OUT1 = 1'b0;
    localparam logic DEST_OUT2 = 1'b1;

endpackage

// File: rtl/crossbar_out_arbiter.sv
// Per-output arbiter: lock FSM, round-robin pointer and output beat register.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | no owner; grant a candidate input at the next edge
//   LOCK_IN1 | output owned by in1 until its last beat is accepted
//   LOCK_IN2 | output owned by in2 until its last beat is accepted
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req_valid/req_dest  raw valid and destination of both inputs (bit0 = in1)
//   excl                inputs locked by the other output, never candidates here
//   beat_valid/data/last  owner's beat, muxed by sel at the top level
//   out_ready           downstream accepts the registered beat
//   lock                one-hot owner (bit0 = in1, bit1 = in2)
//   accept              output register can take a beat this cycle
//   sel, busy           crossbar select, output locked
//   out_valid/data/last registered beat toward downstream
module crossbar_out_arbiter
    import crossbar_pkg::*;
#(
    parameter int   DATA_W = 8,
    parameter logic OUT_ID = DEST_OUT1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_dest,
    input  logic [1:0]        excl,
    input  logic              beat_valid,
    input  logic [DATA_W-1:0] beat_data,
    input  logic              beat_last,
    input  logic              out_ready,
    output logic [1:0]        lock,
    output logic              accept,
    output logic              sel,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    xbar_state_t state;
    logic        rr;
    logic [1:0]  cand;
    logic        fire;

    assign cand[0] = req_valid[0] && (req_dest[0] == OUT_ID) && !excl[0];
    assign cand[1] = req_valid[1] && (req_dest[1] == OUT_ID) && !excl[1];

    assign accept = !out_valid || out_ready;
    assign busy   = (state != IDLE);
    assign lock   = {state == LOCK_IN2, state == LOCK_IN1};
    // sel always names the owner while locked, so beat_valid is the owner's valid.
    assign fire   = busy && accept && beat_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rr    <= 1'b0;
            sel   <= SEL_IN1;
        end else begin
            case (state)
                IDLE: begin
                    if (cand == 2'b11) begin
                        // Contested: rr=0 favours in1; flip so the loser wins next time.
                        state <= rr ? LOCK_IN2 : LOCK_IN1;
                        sel   <= rr ? SEL_IN2 : SEL_IN1;
                        rr    <= !rr;
                    end else if (cand[0]) begin
                        state <= LOCK_IN1;
                        sel   <= SEL_IN1;
                    end else if (cand[1]) begin
                        state <= LOCK_IN2;
                        sel   <= SEL_IN2;
                    end
                end
                LOCK_IN1, LOCK_IN2: begin
                    if (fire && beat_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= beat_data;
            out_last  <= beat_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/crossbar_arbiter.sv
// 2x2 crossbar sequencing controller. Two input ports carry valid/ready
// bursts with a destination bit; each output is locked to one input for a
// whole burst, with round-robin on contention, and registers one beat.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   in{1,2}_valid/data/dest/last      upstream beats (dest 0 = out1, 1 = out2)
//   in{1,2}_ready                     upstream beat accepted when valid && ready
//   out{1,2}_valid/data/last          registered beats toward downstream
//   out{1,2}_ready                    downstream accepts
//   sel1, sel2                        crossbar select (0 = in1, 1 = in2)
//   busy1, busy2                      output currently locked
module crossbar_arbiter
    import crossbar_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_dest,
    input  logic              in1_last,
    output logic              in1_ready,
    input  logic              in2_valid,
    input  logic [DATA_W-1:0] in2_data,
    input  logic              in2_dest,
    input  logic              in2_last,
    output logic              in2_ready,
    output logic              out1_valid,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_last,
    input  logic              out1_ready,
    output logic              out2_valid,
    output logic [DATA_W-1:0] out2_data,
    output logic              out2_last,
    input  logic              out2_ready,
    output logic              sel1,
    output logic              sel2,
    output logic              busy1,
    output logic              busy2
);

    logic [1:0]        req_valid;
    logic [1:0]        req_dest;
    logic [1:0]        lock1, lock2;
    logic              accept1, accept2;
    logic              bvalid1, bvalid2;
    logic [DATA_W-1:0] bdata1, bdata2;
    logic              blast1, blast2;

    assign req_valid = {in2_valid, in1_valid};
    assign req_dest  = {in2_dest, in1_dest};

    assign bvalid1 = (sel1 == SEL_IN2) ? in2_valid : in1_valid;
    assign bdata1  = (sel1 == SEL_IN2) ? in2_data  : in1_data;
    assign blast1  = (sel1 == SEL_IN2) ? in2_last  : in1_last;
    assign bvalid2 = (sel2 == SEL_IN2) ? in2_valid : in1_valid;
    assign bdata2  = (sel2 == SEL_IN2) ? in2_data  : in1_data;
    assign blast2  = (sel2 == SEL_IN2) ? in2_last  : in1_last;

    // Ready depends only on lock state and the output register, never on valid.
    assign in1_ready = (lock1[0] && accept1) || (lock2[0] && accept2);
    assign in2_ready = (lock1[1] && accept1) || (lock2[1] && accept2);

    crossbar_out_arbiter #(.DATA_W(DATA_W), .OUT_ID(DEST_OUT1)) u_arb1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_dest   (req_dest),
        .excl       (lock2),
        .beat_valid (bvalid1),
        .beat_data  (bdata1),
        .beat_last  (blast1),
        .out_ready  (out1_ready),
        .lock       (lock1),
        .accept     (accept1),
        .sel        (sel1),
        .busy       (busy1),
        .out_valid  (out1_valid),
        .out_data   (out1_data),
        .out_last   (out1_last)
    );

    crossbar_out_arbiter #(.DATA_W(DATA_W), .OUT_ID(DEST_OUT2)) u_arb2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_dest   (req_dest),
        .excl       (lock1),
        .beat_valid (bvalid2),
        .beat_data  (bdata2),
        .beat_last  (blast2),
        .out_ready  (out2_ready),
        .lock       (lock2),
        .accept     (accept2),
        .sel        (sel2),
        .busy       (busy2),
        .out_valid  (out2_valid),
        .out_data   (out2_data),
        .out_last   (out2_last)
    );

endmodule

// File: tb/tb_crossbar_arbiter.sv
module tb_crossbar_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in1_valid, in1_dest, in1_last, in1_ready;
    logic       in2_valid, in2_dest, in2_last, in2_ready;
    logic [7:0] in1_data, in2_data;
    logic       out1_valid, out1_last, out1_ready;
    logic       out2_valid, out2_last, out2_ready;
    logic [7:0] out1_data, out2_data;
    logic       sel1, sel2, busy1, busy2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] q1[$];
    logic [8:0] q2[$];

    crossbar_arbiter #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in1_valid  (in1_valid),
        .in1_data   (in1_data),
        .in1_dest   (in1_dest),
        .in1_last   (in1_last),
        .in1_ready  (in1_ready),
        .in2_valid  (in2_valid),
        .in2_data   (in2_data),
        .in2_dest   (in2_dest),
        .in2_last   (in2_last),
        .in2_ready  (in2_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_last  (out1_last),
        .out1_ready (out1_ready),
        .out2_valid (out2_valid),
        .out2_data  (out2_data),
        .out2_last  (out2_last),
        .out2_ready (out2_ready),
        .sel1       (sel1),
        .sel2       (sel2),
        .busy1      (busy1),
        .busy2      (busy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each handshake on an output pops the next expected {last,data}.
    always @(negedge clk) begin
        logic [8:0] exp;
        if (rst_n && out1_valid && out1_ready) begin
            exp = (q1.size() > 0) ? q1.pop_front() : 9'bx;
            check("out1_beat", {23'd0, out1_last, out1_data}, {23'd0, exp});
        end
        if (rst_n && out2_valid && out2_ready) begin
            exp = (q2.size() > 0) ? q2.pop_front() : 9'bx;
            check("out2_beat", {23'd0, out2_last, out2_data}, {23'd0, exp});
        end
    end

    task automatic set_in(input int port, input logic v, input logic d,
                          input logic [7:0] dat, input logic l);
        if (port == 1) begin
            in1_valid = v; in1_dest = d; in1_data = dat; in1_last = l;
        end else begin
            in2_valid = v; in2_dest = d; in2_data = dat; in2_last = l;
        end
    endtask

    task automatic wait_accept(input int port);
        int   cyc = 0;
        logic rdy = 1'b0;
        forever begin
            @(negedge clk);
            rdy = (port == 1) ? in1_ready : in2_ready;
            if (rdy || cyc >= 200) break;
            cyc++;
        end
        check($sformatf("accept_in%0d", port), {31'd0, rdy}, 32'd1);
        @(posedge clk); #1;
    endtask

    // Beats from flip_at onward present the inverted dest (ignored while locked).
    task automatic send_burst(input int port, input logic dest, input int n,
                              input logic [7:0] base, input int flip_at);
        for (int b = 0; b < n; b++) begin
            set_in(port, 1'b1, (b >= flip_at) ? !dest : dest, base + 8'(b), b == n - 1);
            wait_accept(port);
        end
        set_in(port, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic push_burst(input int o, input logic [7:0] base, input int n);
        for (int b = 0; b < n; b++) begin
            if (o == 1) q1.push_back({b == n - 1, base + 8'(b)});
            else        q2.push_back({b == n - 1, base + 8'(b)});
        end
    endtask

    task automatic check_reset(input string w);
        check({w, "_in1_ready"},  {31'd0, in1_ready},  0);
        check({w, "_in2_ready"},  {31'd0, in2_ready},  0);
        check({w, "_out1_valid"}, {31'd0, out1_valid}, 0);
        check({w, "_out2_valid"}, {31'd0, out2_valid}, 0);
        check({w, "_out1_data"},  {24'd0, out1_data},  0);
        check({w, "_out2_data"},  {24'd0, out2_data},  0);
        check({w, "_out1_last"},  {31'd0, out1_last},  0);
        check({w, "_out2_last"},  {31'd0, out2_last},  0);
        check({w, "_sel1"},       {31'd0, sel1},       0);
        check({w, "_sel2"},       {31'd0, sel2},       0);
        check({w, "_busy1"},      {31'd0, busy1},      0);
        check({w, "_busy2"},      {31'd0, busy2},      0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] own_log [16];
        logic [1:0] exp_log [16] = '{2, 0, 0, 0, 2, 1, 1, 1, 2, 0, 0, 0, 2, 1, 1, 1};
        logic       seen_busy2;

        rst_n = 1'b0;
        set_in(1, 0, 0, 8'h00, 0);
        set_in(2, 0, 0, 8'h00, 0);
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        idle(2);
        check_reset("rst");
        rst_n = 1'b1;
        idle(1);

        // Single beat in1 -> out2
        push_burst(2, 8'hA5, 1);
        fork
            send_burst(1, 1'b1, 1, 8'hA5, 1);
            begin
                @(negedge clk);
                check("single_ready_c0", {31'd0, in1_ready}, 0);
                @(negedge clk);
                check("single_ready_c1", {31'd0, in1_ready}, 1);
                check("single_busy2_c1", {31'd0, busy2}, 1);
                check("single_sel2", {31'd0, sel2}, 0);
                @(negedge clk);
                check("single_out2_valid", {31'd0, out2_valid}, 1);
                check("single_out2_last", {31'd0, out2_last}, 1);
                check("single_out2_data", {24'd0, out2_data}, 32'hA5);
                check("single_out1_valid", {31'd0, out1_valid}, 0);
            end
        join
        idle(3);

        // Parallel: in1 -> out2, in2 -> out1
        push_burst(2, 8'hB0, 1);
        push_burst(1, 8'hC0, 1);
        fork
            send_burst(1, 1'b1, 1, 8'hB0, 1);
            send_burst(2, 1'b0, 1, 8'hC0, 1);
            begin
                @(negedge clk);
                @(negedge clk);
                check("par_busy1", {31'd0, busy1}, 1);
                check("par_busy2", {31'd0, busy2}, 1);
                check("par_sel1", {31'd0, sel1}, 1);
                check("par_sel2", {31'd0, sel2}, 0);
                @(negedge clk);
                check("par_out1_valid", {31'd0, out1_valid}, 1);
                check("par_out2_valid", {31'd0, out2_valid}, 1);
            end
        join
        idle(3);
        check("par_sel1_hold", {31'd0, sel1}, 1);
        check("par_busy1_idle", {31'd0, busy1}, 0);

        // Contention: two 3-beat bursts from each input to out1
        push_burst(1, 8'h10, 3);
        push_burst(1, 8'h20, 3);
        push_burst(1, 8'h30, 3);
        push_burst(1, 8'h40, 3);
        fork
            begin
                send_burst(1, 1'b0, 3, 8'h10, 3);
                send_burst(1, 1'b0, 3, 8'h30, 3);
            end
            begin
                send_burst(2, 1'b0, 3, 8'h20, 3);
                send_burst(2, 1'b0, 3, 8'h40, 3);
            end
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                own_log[i] = busy1 ? {1'b0, sel1} : 2'd2;
            end
        join
        for (int i = 0; i < 16; i++)
            check($sformatf("rr_owner_c%0d", i), {30'd0, own_log[i]}, {30'd0, exp_log[i]});
        idle(3);

        // Backpressure: out1_ready low for 4 cycles mid-burst
        push_burst(1, 8'h50, 4);
        fork
            send_burst(1, 1'b0, 4, 8'h50, 4);
            begin
                idle(3);
                out1_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("bp_in1_ready", {31'd0, in1_ready}, 0);
                    check("bp_out1_hold", {23'd0, out1_valid, out1_data}, {23'd0, 1'b1, 8'h51});
                    @(posedge clk); #1;
                end
                out1_ready = 1'b1;
            end
        join
        idle(3);

        // Lock exclusion: in1 flips dest to out2 mid-burst while locked on out1
        push_burst(1, 8'h60, 4);
        seen_busy2 = 1'b0;
        fork
            send_burst(1, 1'b0, 4, 8'h60, 2);
            repeat (7) begin
                @(negedge clk);
                if (busy2) seen_busy2 = 1'b1;
            end
        join
        check("lockx_out2_idle", {31'd0, seen_busy2}, 0);
        idle(3);

        // Reset during beat 2 of 4; only beat 1 reached the output first
        push_burst(1, 8'h70, 0);
        q1.push_back({1'b0, 8'h70});
        set_in(1, 1'b1, 1'b0, 8'h70, 1'b0);
        idle(1);
        idle(1);
        set_in(1, 1'b1, 1'b0, 8'h71, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset("midrst");
        set_in(1, 0, 0, 8'h00, 0);
        idle(1);
        rst_n = 1'b1;
        idle(2);

        // Fresh in2 request after reset, then rr must favour in1 again
        push_burst(1, 8'h80, 1);
        send_burst(2, 1'b0, 1, 8'h80, 1);
        idle(2);
        push_burst(1, 8'h90, 1);
        push_burst(1, 8'hA0, 1);
        fork
            send_burst(1, 1'b0, 1, 8'h90, 1);
            send_burst(2, 1'b0, 1, 8'hA0, 1);
        join
        idle(4);

        check("sb_q1_empty", q1.size(), 0);
        check("sb_q2_empty", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/crossbar_arbiter.md
# crossbar_arbiter

Sequencing controller for the 2x2, 8-bit crossbar datapath. Accepts valid/ready bursts from two input ports, each carrying a destination output, and arbitrates round-robin when both target the same output. It locks the crossbar path for a whole burst, drives the crossbar select lines, and registers one beat per output toward downstream consumers.

## Interface
- `DATA_W`, 8, beat width for the input and output data buses.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in1_valid`, `in2_valid`  input  1  beat present on input port.
- `in1_data`, `in2_data`  input  DATA_W  beat payload.
- `in1_dest`, `in2_dest`  input  1  requested output: 0 = out1, 1 = out2. Sampled only at grant.
- `in1_last`, `in2_last`  input  1  final beat of burst.
- `in1_ready`, `in2_ready`  output  1  beat accepted when valid && ready.
- `out1_valid`, `out2_valid`  output  1  registered beat available.
- `out1_data`, `out2_data`  output  DATA_W  registered payload.
- `out1_last`, `out2_last`  output  1  registered last flag.
- `out1_ready`, `out2_ready`  input  1  downstream accepts.
- `sel1`, `sel2`  output  1  crossbar select, 0 = in1, 1 = in2. Reflects the current or most recent owner.
- `busy1`, `busy2`  output  1  output currently locked to an input.

## Operation
- Each output o runs a separate 3-state FSM: IDLE, LOCK_IN1, LOCK_IN2.
- An input is a candidate for output o when all of the following hold:
  - its valid is 1;
  - its dest equals o;
  - it is not currently locked by the other output.
- IDLE transitions:
  - One candidate: go to LOCK_INx at the next edge.
  - Two candidates: grant the input favoured by the round-robin pointer `rr_o`, then flip `rr_o` to favour the other input.
  - No candidates: stay in IDLE.
- `rr_o` reset value is 0, favouring in1. The pointer changes only on a contested grant.
- In LOCK_INx, dest is ignored: every beat of input x goes to output o until the `last` beat is accepted, then the FSM returns to IDLE at that edge.
- Output register accepts a beat when `!out_valid || out_ready`.
- `inx_ready` = (output o locked to x) && (output register of o accepts). Ready is 0 for an input with no lock.
- On an accepted beat, the output register loads the data and last flag and sets `out_valid`. Otherwise, when `out_ready` is asserted, `out_valid` clears.
- `sel_o` updates on entry to LOCK_INx and holds its value through IDLE.
- Simultaneous events:
  - Both inputs target different outputs: both are granted in the same cycle, independently.
  - Input 1 is locked on out1 while input 2 targets out1: input 2 waits. Input 2 is never redirected.
  - Last beat accepted while the other input is requesting: the FSM passes through IDLE, so there is one idle cycle before the next grant.
- Reset (any time, including mid-burst): all FSMs go to IDLE and `rr` pointers clear. The partial burst is dropped, and upstream must restart it.

## Timing
- Reset values:
  - `in*_ready` = 0
  - `out*_valid` = 0
  - `out*_data` = 0
  - `out*_last` = 0
  - `sel1` = 0, `sel2` = 0
  - `busy1` = 0, `busy2` = 0
- Grant latency: valid asserted in cycle N, lock state at edge N+1, first beat accepted in cycle N+1 at the earliest.
- Data latency: a beat accepted in cycle M appears on `out_data` in cycle M+1.
- Throughput: 1 beat/cycle per output while `out_ready` stays 1.
- `in*_ready` is combinational from FSM state, `out_valid` and `out_ready` only. It has no path from `in*_valid`.
- Upstream must hold valid, data and last stable until accepted.

## Structure
- Package `crossbar_pkg`:
  - FSM state enum `xbar_state_t` (IDLE, LOCK_IN1, LOCK_IN2);
  - `SEL_IN1` = 0 and `SEL_IN2` = 1;
  - `DEST_OUT1` = 0 and `DEST_OUT2` = 1.
- Sub-module `crossbar_out_arbiter`, instantiated twice, contains:
  - the FSM;
  - the `rr` pointer;
  - the output register.
- Each instance receives the other instance's lock vector as an exclusion mask. The top level builds the ready signals and muxes data by `sel`.

## Test plan
- Single beat: in1 sends 0xA5, dest=1, last=1, out2_ready=1 → in1_ready high in cycle 1, out2_data=0xA5 with out2_last=1 in cycle 2, sel2=0, out1_valid stays 0.
- Parallel paths: in1→out2 and in2→out1 in the same cycle → both granted at edge 1, both outputs valid in cycle 2, sel1=1, sel2=0.
- Contention: both inputs send 3-beat bursts to out1 twice in a row → order is in1 burst, in2 burst, in1 burst, in2 burst, with no interleaving inside a burst and one idle cycle between bursts.
- Backpressure: out1_ready=0 for 4 cycles mid-burst → at most one beat is held and in1_ready=0 throughout. No beat is lost or duplicated, and beat order is preserved.
- Lock exclusion: in1 is locked on out1 mid-burst and then presents dest=1 → its beats still go to out1, and out2 stays IDLE.
- Reset mid-burst: assert rst_n=0 during beat 2 of 4 → all outputs return to their reset values immediately. After release, a fresh in2 request is granted first.
